// File: rtl/sfp_status_pkg.sv
// Shared constants for the SFP cage status conditioner: bit positions,
// status width and the default power-on status value.
package sfp_status_pkg;

  localparam int SFP_STATUS_W = 3;

  localparam int SFP_TX_FAULT = 0;
  localparam int SFP_RX_LOS   = 1;
  localparam int SFP_MOD_ABS  = 2;

  // Module absent and no signal until the pins say otherwise
  localparam logic [SFP_STATUS_W-1:0] SFP_STATUS_RESET_DEFAULT = 3'b110;

endpackage

// File: rtl/sfp_status_debounce_bit.sv
// One SFP status bit: 2-flop synchroniser, debounce counter and status flop,
// with a strobe marking the edge on which the status flop takes a new value.
module sfp_status_debounce_bit
  import sfp_status_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_status,
  output logic o_changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_status;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mismatch;
  logic             w_accept;

  assign w_mismatch = (r_sync2 != r_status);
  assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any return to the current status restarts the persistence window
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_status <= RESET_VAL;
    end else if (!w_mismatch) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_status <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_status  = r_status;
  assign o_changed = w_accept;

endmodule

// File: rtl/sfp_status_conditioner.sv
// Conditions the asynchronous SFP cage pins for the status PIO: per-bit
// debounce, sticky change flags and a settle flag; SFP_STATUS_IRQ_EN adds a masked irq.
module sfp_status_conditioner
  import sfp_status_pkg::*;
#(
  parameter int                      DEBOUNCE_CYCLES = 16,
  parameter logic [SFP_STATUS_W-1:0] STATUS_RESET    = SFP_STATUS_RESET_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SFP_STATUS_W-1:0] sfp_raw,
  input  logic [SFP_STATUS_W-1:0] sticky_clr,
`ifdef SFP_STATUS_IRQ_EN
  input  logic [SFP_STATUS_W-1:0] irq_mask,
`endif
  output logic [SFP_STATUS_W-1:0] status_out,
  output logic [SFP_STATUS_W-1:0] change_sticky,
  output logic                    status_valid
`ifdef SFP_STATUS_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int SETTLE_W = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(DEBOUNCE_CYCLES + 1);

  logic [SFP_STATUS_W-1:0] w_changed;
  logic [SFP_STATUS_W-1:0] r_sticky;
  logic [SETTLE_W-1:0]     r_settle;
  logic                    r_valid;

  for (genvar gi = 0; gi < SFP_STATUS_W; gi++) begin : g_bit
    sfp_status_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (STATUS_RESET[gi])
    ) u_debounce (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_raw    (sfp_raw[gi]),
      .o_status (status_out[gi]),
      .o_changed(w_changed[gi])
    );
  end

  // A new change outranks a clear landing on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~sticky_clr) | w_changed;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_settle <= '0;
      r_valid  <= 1'b0;
    end else if (!r_valid) begin
      if (r_settle == SETTLE_LAST) begin
        r_valid <= 1'b1;
      end else begin
        r_settle <= r_settle + 1'b1;
      end
    end
  end

  assign change_sticky = r_sticky;
  assign status_valid  = r_valid;

`ifdef SFP_STATUS_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_sticky & irq_mask);
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_sfp_status_conditioner.sv
// Bench for sfp_status_conditioner at DEBOUNCE_CYCLES=4: directed vectors,
// a window-based reference model checked every cycle, and pinned literals.
module tb_sfp_status_conditioner;

  localparam int D = 4;
  localparam logic [2:0] RST_VAL = 3'b110;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] sfp_raw = 3'b000;
  logic [2:0] sticky_clr = 3'b000;
  logic [2:0] irq_mask = 3'b100;
  logic [2:0] status_out;
  logic [2:0] change_sticky;
  logic       status_valid;
`ifdef SFP_STATUS_IRQ_EN
  logic       irq;
`endif

  int errors = 0;
  int checks = 0;

  sfp_status_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .STATUS_RESET   (RST_VAL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sfp_raw      (sfp_raw),
    .sticky_clr   (sticky_clr),
`ifdef SFP_STATUS_IRQ_EN
    .irq_mask     (irq_mask),
`endif
    .status_out   (status_out),
    .change_sticky(change_sticky),
    .status_valid (status_valid)
`ifdef SFP_STATUS_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a bit flips once its last D synchronised samples all disagree with it
  logic [2:0]   mS1, mS2, mStatus, mSticky, mUpd;
  logic [D-1:0] mHist [3];
  int           mSettle;
  logic         mValid, mIrq, mReady = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mS1 = RST_VAL;
      mS2 = RST_VAL;
      mStatus = RST_VAL;
      mSticky = 3'b000;
      mSettle = 0;
      mValid = 1'b0;
      mIrq = 1'b0;
      for (int i = 0; i < 3; i++) mHist[i] = {D{RST_VAL[i]}};
      mReady = 1'b1;
    end else begin
      mIrq = |(mSticky & irq_mask);
      for (int i = 0; i < 3; i++) begin
        mHist[i] = {mHist[i][D-2:0], mS2[i]};
        mUpd[i] = (mHist[i] == {D{~mStatus[i]}});
      end
      mSticky = (mSticky & ~sticky_clr) | mUpd;
      mStatus = mStatus ^ mUpd;
      mS2 = mS1;
      mS1 = sfp_raw;
      mSettle++;
      mValid = (mSettle >= D + 2);
    end
  end

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mReady) begin
      checkOutput("model.status", status_out, mStatus);
      checkOutput("model.sticky", change_sticky, mSticky);
      checkOutput("model.valid", {2'b00, status_valid}, {2'b00, mValid});
`ifdef SFP_STATUS_IRQ_EN
      checkOutput("model.irq", {2'b00, irq}, {2'b00, mIrq});
`endif
    end
  end

  // Drive new pins plus a one-cycle clear, then let n falling edges pass
  task automatic applyStimulus(input logic [2:0] raw, input logic [2:0] clr, input int n);
    sfp_raw = raw;
    sticky_clr = clr;
    @(negedge clk);
    sticky_clr = 3'b000;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset.status", status_out, 3'b110);
    checkOutput("reset.sticky", change_sticky, 3'b000);
    checkOutput("reset.valid", {2'b00, status_valid}, 3'b000);
    sfp_raw = 3'b110;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("settle.early", {2'b00, status_valid}, 3'b000);
    @(negedge clk);
    checkOutput("settle.done", {2'b00, status_valid}, 3'b001);

    applyStimulus(3'b100, 3'b000, 5);
    checkOutput("accept.before", status_out, 3'b110);
    @(negedge clk);
    checkOutput("accept.status", status_out, 3'b100);
    checkOutput("accept.sticky", change_sticky, 3'b010);

    applyStimulus(3'b100, 3'b111, 1);
    checkOutput("glitch.cleared", change_sticky, 3'b000);
    applyStimulus(3'b110, 3'b000, 3);
    applyStimulus(3'b100, 3'b000, 8);
    checkOutput("glitch3.status", status_out, 3'b100);
    checkOutput("glitch3.sticky", change_sticky, 3'b000);
    applyStimulus(3'b110, 3'b000, 4);
    applyStimulus(3'b100, 3'b000, 2);
    checkOutput("pulse4.status", status_out, 3'b110);
    checkOutput("pulse4.sticky", change_sticky, 3'b010);
    repeat (8) @(negedge clk);
    checkOutput("pulse4.revert", status_out, 3'b100);

    applyStimulus(3'b100, 3'b111, 1);
    applyStimulus(3'b101, 3'b000, 5);
    applyStimulus(3'b101, 3'b001, 1);
    checkOutput("race.status", status_out, 3'b101);
    checkOutput("race.sticky", change_sticky, 3'b001);
    applyStimulus(3'b101, 3'b001, 1);
    checkOutput("clear.sticky", change_sticky, 3'b000);

    applyStimulus(3'b001, 3'b000, 3);
    #2 reset = 1'b1;
    sfp_raw = 3'b110;
    #1;
    checkOutput("midreset.status", status_out, 3'b110);
    checkOutput("midreset.sticky", change_sticky, 3'b000);
    checkOutput("midreset.valid", {2'b00, status_valid}, 3'b000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("release.status", status_out, 3'b110);
    checkOutput("release.sticky", change_sticky, 3'b000);
    checkOutput("release.valid", {2'b00, status_valid}, 3'b001);

`ifdef SFP_STATUS_IRQ_EN
    applyStimulus(3'b100, 3'b000, 8);
    checkOutput("irq.rxlos.sticky", change_sticky, 3'b010);
    checkOutput("irq.rxlos.irq", {2'b00, irq}, 3'b000);
    applyStimulus(3'b100, 3'b111, 1);
    applyStimulus(3'b000, 3'b000, 6);
    checkOutput("irq.modabs.sticky", change_sticky, 3'b100);
    checkOutput("irq.modabs.lag", {2'b00, irq}, 3'b000);
    @(negedge clk);
    checkOutput("irq.modabs.irq", {2'b00, irq}, 3'b001);
    applyStimulus(3'b000, 3'b100, 1);
    checkOutput("irq.clr.sticky", change_sticky, 3'b000);
    checkOutput("irq.clr.lag", {2'b00, irq}, 3'b001);
    @(negedge clk);
    checkOutput("irq.clr.irq", {2'b00, irq}, 3'b000);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
